psram_rd_cache: RTL and testbench

- Small direct-mapped read cache between the AHB-side request logic and the PSRAM controller core's start/done transaction port.
- Read hits are served in one cycle without touching the PSRAM.
- A read miss fills a 16-byte line using four sequential word reads on the core port.
- Writes are write-through and no-allocate; a hit line is also updated in place.

---
 rtl/psram_rd_cache_if.sv | 27 ++
 rtl/psram_rd_cache.sv | 118 +++++++++++
 tb/tb_psram_rd_cache.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/psram_rd_cache_if.sv
// psram_rd_cache_if: request/response and PSRAM core transaction signals for the read cache
interface psram_rd_cache_if #(parameter int AW = 24);
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [2:0]    req_size;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          inv;
    logic          mem_start;
    logic          mem_done;
    logic [AW-1:0] mem_addr;
    logic [2:0]    mem_size;
    logic          mem_rd_wr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    modport slave (
        input  req_valid, req_write, req_addr, req_size, req_wdata, inv, mem_done, mem_rdata,
        output req_ready, resp_valid, resp_rdata, mem_start, mem_addr, mem_size, mem_rd_wr, mem_wdata
    );
    modport master (
        output req_valid, req_write, req_addr, req_size, req_wdata, inv, mem_done, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, mem_start, mem_addr, mem_size, mem_rd_wr, mem_wdata
    );
endinterface

// File: rtl/psram_rd_cache.sv
// psram_rd_cache: direct-mapped write-through read cache in front of the PSRAM core start/done port
module psram_rd_cache #(
    parameter int LINES = 4,
    parameter int AW    = 24
) (
    input logic clk,
    input logic rst,
    psram_rd_cache_if.slave bus
);
    localparam int IW = $clog2(LINES);
    localparam int TW = AW - 4 - IW;
    typedef enum logic [2:0] {IDLE, FILL_ISSUE, FILL_WAIT, WR_WAIT, RESP} state_t;
    state_t state;
    logic [LINES-1:0] vld;
    logic [TW-1:0] tags [LINES];
    logic [31:0] data [LINES][4];
    logic [AW-1:2] r_addr;
    logic wr;
    logic [1:0] k;
    logic poison;
    logic [IW-1:0] req_idx, idx;
    logic [TW-1:0] req_tag, tag;
    logic hit, accept;
    logic [3:0] be;
    function automatic logic [3:0] lanes(input logic [2:0] sz, input logic [1:0] o);
        return sz == 3'd4 ? 4'hf : sz == 3'd2 ? (o[1] ? 4'hc : 4'h3) : 4'b0001 << o;
    endfunction
    assign req_idx = bus.req_addr[4 +: IW];
    assign req_tag = bus.req_addr[AW-1 -: TW];
    assign idx = r_addr[4 +: IW];
    assign tag = r_addr[AW-1 -: TW];
    assign hit = !bus.inv && vld[req_idx] && tags[req_idx] == req_tag;
    assign accept = bus.req_valid && bus.req_ready;
    assign be = lanes(bus.req_size, bus.req_addr[1:0]);
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            vld            <= '0;
            r_addr         <= '0;
            wr             <= 1'b0;
            k              <= 2'd0;
            poison         <= 1'b0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= 32'h0;
            bus.mem_start  <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_size   <= 3'd4;
            bus.mem_rd_wr  <= 1'b1;
            bus.mem_wdata  <= 32'h0;
        end else begin
            bus.resp_valid <= 1'b0;
            bus.mem_start  <= 1'b0;
            if (bus.inv) vld <= '0;
            case (state)
                IDLE: if (accept) begin
                    r_addr <= bus.req_addr[AW-1:2];
                    wr     <= bus.req_write;
                    k      <= 2'd0;
                    poison <= 1'b0;
                    if (bus.req_write) begin
                        state         <= WR_WAIT;
                        bus.req_ready <= 1'b0;
                        bus.mem_start <= 1'b1;
                        bus.mem_addr  <= bus.req_addr;
                        bus.mem_size  <= bus.req_size;
                        bus.mem_rd_wr <= 1'b0;
                        bus.mem_wdata <= bus.req_wdata;
                        if (hit)
                            for (int b = 0; b < 4; b++)
                                if (be[b]) data[req_idx][bus.req_addr[3:2]][8*b +: 8] <= bus.req_wdata[8*b +: 8];
                    end else if (hit) begin
                        bus.resp_valid <= 1'b1;
                        bus.resp_rdata <= data[req_idx][bus.req_addr[3:2]];
                    end else begin
                        // the line is rewritten word by word, so it must not look valid meanwhile
                        state         <= FILL_ISSUE;
                        vld[req_idx]  <= 1'b0;
                        bus.req_ready <= 1'b0;
                        bus.mem_start <= 1'b1;
                        bus.mem_addr  <= {bus.req_addr[AW-1:4], 4'h0};
                        bus.mem_size  <= 3'd4;
                        bus.mem_rd_wr <= 1'b1;
                    end
                end
                FILL_ISSUE: begin
                    state  <= FILL_WAIT;
                    poison <= poison | bus.inv;
                end
                FILL_WAIT: begin
                    poison <= poison | bus.inv;
                    if (bus.mem_done) begin
                        data[idx][k] <= bus.mem_rdata;
                        if (k == 2'd3) state <= RESP;
                        else begin
                            state         <= FILL_ISSUE;
                            k             <= k + 2'd1;
                            bus.mem_start <= 1'b1;
                            bus.mem_addr  <= {r_addr[AW-1:4], k + 2'd1, 2'b00};
                        end
                    end
                end
                WR_WAIT: if (bus.mem_done) state <= RESP;
                RESP: begin
                    state          <= IDLE;
                    bus.req_ready  <= 1'b1;
                    bus.resp_valid <= 1'b1;
                    bus.resp_rdata <= wr ? 32'h0 : data[idx][r_addr[3:2]];
                    if (!wr) begin
                        tags[idx] <= tag;
                        if (!(poison || bus.inv)) vld[idx] <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_psram_rd_cache.sv
// tb_psram_rd_cache: random and directed checks of the read cache against a cache/memory reference model
module tb_psram_rd_cache;
    localparam int LINES = 4;
    localparam int AW    = 24;
    typedef struct {
        logic        rw;
        logic [23:0] a;
        logic [2:0]  s;
        logic [31:0] d;
    } txn_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_err = 0;
    int lat_sum = 0;
    txn_t log_q[$];
    logic [7:0] mb [int];
    bit [LINES-1:0] mvalid = '0;
    int mtag [LINES];
    psram_rd_cache_if #(.AW(AW)) bus ();
    psram_rd_cache #(.LINES(LINES), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    function automatic logic [31:0] def_word(input int w);
        return (w >= 'h40 && w <= 'h43) ? 32'(32'hA0 + w - 'h40) : 32'(w * 32'h9E3779B1);
    endfunction
    function automatic logic [7:0] rd_byte(input int a);
        logic [31:0] w;
        if (mb.exists(a)) return mb[a];
        w = def_word(a >> 2);
        return w[8*(a%4) +: 8];
    endfunction
    function automatic logic [31:0] rd_word(input int a);
        int b;
        b = a & ~3;
        return {rd_byte(b+3), rd_byte(b+2), rd_byte(b+1), rd_byte(b)};
    endfunction
    initial begin
        bus.mem_done  = 1'b0;
        bus.mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            bus.mem_done = 1'b0;
            if (bus.mem_start && !rst) begin
                txn_t t;
                int l;
                t.rw = bus.mem_rd_wr;
                t.a  = bus.mem_addr;
                t.s  = bus.mem_size;
                t.d  = bus.mem_wdata;
                log_q.push_back(t);
                l = $urandom_range(1, 3);
                lat_sum += l + 1;
                if (!t.rw)
                    for (int i = 0; i < int'(t.s); i++)
                        mb[int'(t.a) + i] = t.d[8*((int'(t.a) + i) % 4) +: 8];
                repeat (l) @(negedge clk);
                bus.mem_rdata = t.rw ? rd_word(int'(t.a)) : 32'h0;
                bus.mem_done  = 1'b1;
            end
        end
    end
    task automatic req(input bit wr, input int a, input int sz, input logic [31:0] wd,
                       input bit inv_now, input int inv_at, output logic [31:0] rd);
        int idx, tag, lat, ntx, base;
        bit hit, fired;
        logic [31:0] exp_d;
        idx = (a >> 4) % LINES;
        tag = a >> (4 + $clog2(LINES));
        base = a & ~15;
        @(negedge clk);
        log_q.delete();
        lat_sum = 0;
        if (inv_now) mvalid = '0;
        hit = !wr && mvalid[idx] && mtag[idx] == tag;
        exp_d = wr ? 32'h0 : rd_word(a);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = 24'(a);
        bus.req_size  = 3'(sz);
        bus.req_wdata = wd;
        bus.inv       = inv_now;
        for (int i = 0; i < 20 && !bus.req_ready; i++) @(negedge clk);
        check("req_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.inv = 1'b0;
        lat = 0;
        fired = 1'b0;
        for (int j = 1; j <= 200; j++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                lat = j;
                break;
            end
            bus.inv = (j == inv_at);
            fired |= (j == inv_at);
        end
        bus.inv = 1'b0;
        check("resp_seen", 32'(lat != 0), 32'd1);
        rd = bus.resp_rdata;
        ntx = log_q.size();
        check("rdata", rd, exp_d);
        check("ntx", ntx, wr ? 1 : (hit ? 0 : 4));
        check("latency", lat, hit ? 1 : lat_sum + 2);
        if (wr && ntx > 0) begin
            check("wr_rw", 32'(log_q[0].rw), 32'd0);
            check("wr_addr", 32'(log_q[0].a), a);
            check("wr_size", 32'(log_q[0].s), sz);
            check("wr_data", log_q[0].d, wd);
        end
        if (!wr)
            for (int i = 0; i < ntx && i < 4; i++) begin
                check("fill_addr", 32'(log_q[i].a), base + 4*i);
                check("fill_rw", 32'(log_q[i].rw), 32'd1);
                check("fill_size", 32'(log_q[i].s), 32'd4);
            end
        if (fired) mvalid = '0;
        if (!wr && !hit) begin
            mtag[idx] = tag;
            mvalid[idx] = !fired;
        end
    endtask
    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
    initial begin
        logic [31:0] d;
        int bad;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_size  = 3'd4;
        bus.req_wdata = 32'h0;
        bus.inv       = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'h0);
        check("rst_mem_start", 32'(bus.mem_start), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_mem_size", 32'(bus.mem_size), 32'd4);
        check("rst_mem_rd_wr", 32'(bus.mem_rd_wr), 32'd1);
        check("rst_mem_wdata", bus.mem_wdata, 32'h0);
        rst = 1'b0;
        req(0, 'h104, 4, 0, 0, 0, d);
        check("tp_rd104", d, 32'hA1);
        req(0, 'h10C, 4, 0, 0, 0, d);
        check("tp_rd10c", d, 32'hA3);
        req(1, 'h108, 4, 32'hDEADBEEF, 0, 0, d);
        req(0, 'h108, 4, 0, 0, 0, d);
        check("tp_rd108_word", d, 32'hDEADBEEF);
        req(1, 'h109, 1, 32'h0000_5500, 0, 0, d);
        req(0, 'h108, 4, 0, 0, 0, d);
        check("tp_rd108_byte", d, 32'hDEAD55EF);
        req(0, 'h100, 4, 0, 0, 0, d);
        req(0, 'h140, 4, 0, 0, 0, d);
        req(0, 'h100, 4, 0, 0, 0, d);
        req(0, 'h180, 4, 0, 0, 6, d);
        req(0, 'h180, 4, 0, 0, 0, d);
        req(0, 'h184, 4, 0, 0, 0, d);
        req(0, 'h184, 4, 0, 1, 0, d);
        req(1, 'h200, 4, 32'h12345678, 0, 0, d);
        req(0, 'h200, 4, 0, 0, 0, d);
        check("tp_rd200", d, 32'h12345678);
        @(negedge clk);
        log_q.delete();
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 24'h3C0;
        bus.req_size  = 3'd4;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_fill_started", log_q.size(), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_ready", 32'(bus.req_ready), 32'd1);
        check("mid_rst_mem_start", 32'(bus.mem_start), 32'd0);
        check("mid_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            bad += int'(bus.resp_valid) + int'(bus.mem_start);
        end
        check("mid_rst_quiet", bad, 32'd0);
        mvalid = '0;
        req(0, 'h104, 4, 0, 0, 0, d);
        check("tp_after_rst", d, 32'hA1);
        for (int n = 0; n < 150; n++) begin
            int r, sz, a;
            r = $urandom_range(0, 2);
            sz = r == 0 ? 1 : r == 1 ? 2 : 4;
            a = $urandom_range(0, 'h3FF) & ~(sz - 1);
            req($urandom_range(0, 2) == 0, a, sz, $urandom, $urandom_range(0, 15) == 0,
                $urandom_range(0, 7) == 0 ? $urandom_range(1, 9) : 0, d);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
